rice_bit_feeder: RTL and testbench
==================================

# rice_bit_feeder

Serialises the 16-bit word stream of a FLAC subframe's residual section into the one-bit-per-cycle `iData`/`iEnable` pair consumed by the Rice stream reader, directly upstream of it.
- Applies a start-bit offset, because the residual section rarely begins on a word boundary.
- Double-buffers words so a steady word source yields a gap-free bit stream.
- Honours a downstream hold, so the reader can be paused without losing bits.

## Interface
Parameters: none.

Ports:
- iClock  in  1  sole clock; all state updates on its rising edge.
- iReset  in  1  asynchronous, active-low reset (0 = reset).
- iStart  in  1  one-cycle pulse: flush buffers, latch `iBitOffset`, enter RUN.
- iStop  in  1  one-cycle pulse: flush buffers, enter IDLE.
- iBitOffset  in  4  number of MSBs to discard from the first word after `iStart` (0–15).
- iWord  in  16  input word; bits emitted MSB-first.
- iWordValid  in  1  `iWord` valid.
- oWordReady  out  1  feeder can accept a word this cycle.
- iHold  in  1  downstream pause; no bit emitted while high.
- oData  out  1  serial bit, to the reader's `iData`.
- oEnable  out  1  `oData` valid this cycle, to the reader's `iEnable`.
- oStarved  out  1  RUN, not held, and no bit available last edge.
- oBitsConsumed  out  24  bits emitted since `iStart`; wraps modulo 2^24.

## Operation
- **Internal state:**
  - `state` ∈ {IDLE, RUN}
  - `cur_word[15:0]`, `cur_bits[4:0]` (0–16)
  - `nxt_word[15:0]`, `nxt_valid`
  - `skip[3:0]`
- **Handshake:** `oWordReady = (state==RUN) && !nxt_valid`, combinational from registers only. A word is accepted on an edge where `iWordValid && oWordReady`. `iWord` must be held stable while valid and not ready.
- **Per RUN edge:**
  - `shift = (cur_bits!=0) && !iHold`.
  - If `shift`: `oData <= cur_word[15]`, `oEnable <= 1`, `cur_word <<= 1`, `oBitsConsumed++`. Otherwise `oEnable <= 0` and `oData` holds.
  - `rem = cur_bits - shift`.
  - If `rem==0`, refill `cur` from `nxt` when `nxt_valid` (clearing `nxt_valid`). If `nxt` is empty, refill from the word accepted on this edge. Otherwise `cur_bits <= 0`.
  - If `rem!=0`, an accepted word goes to `nxt`.
  - Refill with pending `skip`: `cur_word <= w << skip`, `cur_bits <= 16 - skip`, `skip <= 0`.
  - `oStarved <= !iHold && (cur_bits==0)`.
- **iStart (any state):** clear `cur_bits`, `nxt_valid` and `oBitsConsumed`; set `skip <= iBitOffset`, `oEnable <= 0`, `oStarved <= 0`, `state <= RUN`. No word is accepted on that edge.
- **iStop (any state):** same flush, `state <= IDLE`.
- **Simultaneous iStart and iStop:** iStart wins.
- **IDLE:** `oEnable = 0`, `oStarved = 0`, `oWordReady = 0`, all state held.
- **Simultaneous events:**
  - `iHold` high during a refill: the refill still occurs if `cur_bits==0`.
  - Acceptance and emission in the same edge are independent.

## Timing
- **Reset values (async assert, sync release):**
  - outputs: `oData = 0`, `oEnable = 0`, `oStarved = 0`, `oBitsConsumed = 0`, `oWordReady = 0`
  - internal: `state = IDLE`, `cur_bits = 0`, `nxt_valid = 0`, `skip = 0`
- **Latency:** a word accepted while `cur` is empty produces its first bit on `oData`/`oEnable` after the next edge (1 cycle).
- **Throughput:** with `iWordValid` held high and `iHold` low, `oEnable` stays high continuously. `nxt` is refilled long before `cur` drains.
- **Outputs are registered.** The reader samples `oData` on the same edge `oEnable` is high. Hold is applied combinationally, so asserting `iHold` in cycle N suppresses the bit registered at edge N.
- **Reset mid-stream:** buffered words are lost; the source must restart via `iStart` after reset release.

## Test plan
- **Reset:** assert `iReset=0` mid-stream, asynchronously between edges → `oEnable`, `oData`, `oStarved` and `oWordReady` drop to 0 and `oBitsConsumed` to 0 before the next edge.
- **Back-to-back words:** `iStart` with offset 0, then words 0xA5C3 and 0x0F0F back-to-back, no hold → 32 consecutive `oEnable` cycles.
  - Bits: 1010010111000011 then 0000111100001111.
  - `oStarved` stays 0; `oBitsConsumed` = 32.
- **Bit offset:** `iStart` with offset 5, word 0x07FF then 0x8000 → 11 ones, then 1, then fifteen 0s; `oBitsConsumed` = 27.
- **Hold:** `iHold` high for 3 cycles after bit 7 of 0xA5C3 → `oEnable` low exactly 3 cycles, bit sequence identical to the back-to-back case, no duplication.
- **Starvation:** a single word then `iWordValid=0` → after 16 bits `oEnable=0` and `oStarved=1`. A new word 0xFFFF arrives → `oEnable=1` one cycle after acceptance and `oStarved` clears.
- **Stop/Start:** `iStop` mid-word, with `nxt` full → `oWordReady=0` and `oEnable=0` next cycle. A following `iStart` with offset 3 and word 0xE000 → no stale bits; first emitted bit 0, 13 bits total.

Source files
------------

// File: rtl/rice_bit_feeder.sv
// rice_bit_feeder: serialises 16-bit residual words into a one-bit-per-cycle stream for the Rice reader.
// Two word buffers (cur/nxt) keep the stream gap-free; the first word after iStart drops iBitOffset MSBs.
module rice_bit_feeder (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iStart,
  input  logic        iStop,
  input  logic [3:0]  iBitOffset,
  input  logic [15:0] iWord,
  input  logic        iWordValid,
  output logic        oWordReady,
  input  logic        iHold,
  output logic        oData,
  output logic        oEnable,
  output logic        oStarved,
  output logic [23:0] oBitsConsumed
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, stateNext;
  logic [15:0] curWord, nxtWord, fillWord;
  logic [4:0]  curBits, rem;
  logic        nxtValid, shift, accept, doFill;
  logic [3:0]  skip;

  always_ff @(posedge iClock or negedge iReset)
    if (!iReset) state <= IDLE;
    else state <= stateNext;

  always_comb stateNext = iStart ? RUN : iStop ? IDLE : state;

  always_comb oWordReady = (state == RUN) && !nxtValid;

  // A refill happens only when cur runs dry on this edge; nxt has priority over the incoming word.
  always_comb begin
    shift    = (curBits != 5'd0) && !iHold;
    rem      = curBits - 5'(shift);
    accept   = iWordValid && oWordReady;
    fillWord = nxtValid ? nxtWord : iWord;
    doFill   = (rem == 5'd0) && (nxtValid || accept);
  end

  always_ff @(posedge iClock or negedge iReset)
    if (!iReset) begin
      curWord       <= '0;
      curBits       <= '0;
      nxtWord       <= '0;
      nxtValid      <= 1'b0;
      skip          <= '0;
      oData         <= 1'b0;
      oEnable       <= 1'b0;
      oStarved      <= 1'b0;
      oBitsConsumed <= '0;
    end else if (iStart || iStop) begin
      curBits       <= '0;
      nxtValid      <= 1'b0;
      oEnable       <= 1'b0;
      oStarved      <= 1'b0;
      oBitsConsumed <= '0;
      if (iStart) skip <= iBitOffset;
    end else if (state == RUN) begin
      oEnable  <= shift;
      oStarved <= !iHold && (curBits == 5'd0);
      if (shift) begin
        oData         <= curWord[15];
        oBitsConsumed <= oBitsConsumed + 24'd1;
      end
      if (doFill) begin
        curWord <= fillWord << skip;
        curBits <= 5'd16 - {1'b0, skip};
        skip    <= '0;
      end else begin
        curWord <= curWord << shift;
        curBits <= rem;
      end
      if (rem == 5'd0 && nxtValid) nxtValid <= 1'b0;
      else if (accept && rem != 5'd0) begin
        nxtValid <= 1'b1;
        nxtWord  <= iWord;
      end
    end else begin
      oEnable  <= 1'b0;
      oStarved <= 1'b0;
    end
endmodule

// File: tb/tb_rice_bit_feeder.sv
// tb_rice_bit_feeder: randomized and directed stimulus against a bit-queue reference model.
// A predictor pushes expected bits/cycle behaviour at each handshake; a monitor pops and compares.
module tb_rice_bit_feeder;
  logic        iClock = 0, iReset = 0, iStart = 0, iStop = 0, iWordValid = 0, iHold = 0;
  logic [3:0]  iBitOffset = 0;
  logic [15:0] iWord = 0;
  logic        oWordReady, oData, oEnable, oStarved;
  logic [23:0] oBitsConsumed;

  rice_bit_feeder dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .iStop(iStop),
    .iBitOffset(iBitOffset), .iWord(iWord), .iWordValid(iWordValid),
    .oWordReady(oWordReady), .iHold(iHold), .oData(oData), .oEnable(oEnable),
    .oStarved(oStarved), .oBitsConsumed(oBitsConsumed)
  );

  always #5 iClock = ~iClock;

  typedef struct {bit en; bit starved; bit clr;} cyc_t;
  int   checks = 0, failures = 0, holdMode = 0;
  bit   live = 0;
  bit   bitQ[$];
  cyc_t cycQ[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predictor: the stream is simply the concatenation of accepted words' bits, minus the
  // offset on the first word; a bit can be emitted on an edge only if it was queued before it.
  initial begin
    cyc_t c;
    bit ev, run;
    int skipPend;
    run = 0;
    skipPend = 0;
    wait (iReset === 1'b1);
    forever begin
      @(negedge iClock);
      if (live) begin
        ev = iStart || iStop;
        if (!run) check("ready_idle", oWordReady, 0);
        c.en      = run && !ev && !iHold && bitQ.size() > 0;
        c.starved = run && !ev && !iHold && bitQ.size() == 0;
        c.clr     = ev;
        cycQ.push_back(c);
        if (ev) begin
          bitQ.delete();
          run = iStart;
          if (iStart) skipPend = int'(iBitOffset);
        end else if (run && iWordValid && oWordReady) begin
          for (int i = 15 - skipPend; i >= 0; i--) bitQ.push_back(iWord[i]);
          skipPend = 0;
        end
      end
    end
  end

  // Monitor
  initial begin
    cyc_t c;
    bit b;
    int cnt;
    cnt = 0;
    wait (iReset === 1'b1);
    forever begin
      @(posedge iClock);
      #1;
      if (live && cycQ.size() > 0) begin
        c = cycQ.pop_front();
        if (c.clr) cnt = 0;
        check("enable", oEnable, c.en);
        check("starved", oStarved, c.starved);
        if (oEnable) begin
          if (bitQ.size() == 0) check("extra_bit", 1, 0);
          else begin
            b = bitQ.pop_front();
            check("data", oData, b);
          end
          cnt++;
        end
        check("consumed", oBitsConsumed, cnt & 24'hFFFFFF);
      end
    end
  end

  always @(posedge iClock) begin
    #2;
    if (holdMode == 1) iHold = ($urandom_range(0, 3) == 0);
  end

  task automatic tick();
    @(posedge iClock);
    #2;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic doStart(int off);
    iStart = 1;
    iBitOffset = 4'(off);
    tick();
    iStart = 0;
  endtask

  task automatic doStop();
    iStop = 1;
    tick();
    iStop = 0;
  endtask

  task automatic sendWord(logic [15:0] w, int gapMax);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    iWord = w;
    iWordValid = 1;
    while (!acc && n < 200) begin
      @(negedge iClock);
      acc = oWordReady;
      tick();
      n++;
    end
    iWordValid = 0;
    if (!acc) check("handshake_timeout", 0, 1);
    repeat ($urandom_range(0, gapMax)) tick();
  endtask

  initial begin
    int n;
    #2;
    check("rst_enable", oEnable, 0);
    check("rst_data", oData, 0);
    check("rst_starved", oStarved, 0);
    check("rst_ready", oWordReady, 0);
    check("rst_consumed", oBitsConsumed, 0);
    #10;
    iReset = 1;
    live = 1;
    tick();

    doStart(0);
    sendWord(16'hA5C3, 0);
    sendWord(16'h0F0F, 0);
    idle(40);
    check("b2b_count", oBitsConsumed, 32);

    doStart(5);
    sendWord(16'h07FF, 0);
    sendWord(16'h8000, 0);
    idle(35);
    check("offset_count", oBitsConsumed, 27);

    doStart(0);
    sendWord(16'hA5C3, 0);
    sendWord(16'h0F0F, 0);
    n = 0;
    while (oBitsConsumed != 24'd7 && n < 40) begin tick(); n++; end
    if (n >= 40) check("hold_wait_timeout", 0, 1);
    iHold = 1;
    idle(3);
    iHold = 0;
    idle(40);
    check("hold_count", oBitsConsumed, 32);

    doStart(0);
    sendWord(16'h1234, 0);
    idle(20);
    check("starve_enable", oEnable, 0);
    check("starve_flag", oStarved, 1);
    sendWord(16'hFFFF, 0);
    idle(20);
    check("starve_count", oBitsConsumed, 32);

    doStart(0);
    sendWord(16'hA5C3, 0);
    sendWord(16'h0F0F, 0);
    tick();
    doStop();
    check("stop_ready", oWordReady, 0);
    check("stop_enable", oEnable, 0);
    idle(3);
    doStart(3);
    sendWord(16'hE000, 0);
    idle(20);
    check("restart_count", oBitsConsumed, 13);

    for (int r = 0; r < 30; r++) begin
      holdMode = int'($urandom_range(0, 1));
      doStart(int'($urandom_range(0, 15)));
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) sendWord(16'($urandom), int'($urandom_range(0, 20)));
      if ($urandom_range(0, 3) == 0) doStop();
      else idle(60);
      holdMode = 0;
      iHold = 0;
    end

    doStart(0);
    iWord = 16'hFFFF;
    iWordValid = 1;
    idle(5);
    live = 0;
    #1;
    iReset = 0;
    #1;
    check("midrst_enable", oEnable, 0);
    check("midrst_data", oData, 0);
    check("midrst_starved", oStarved, 0);
    check("midrst_ready", oWordReady, 0);
    check("midrst_consumed", oBitsConsumed, 0);
    iWordValid = 0;
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
